// File: rtl/decode_stage.sv
// RV32I decode stage: latches the fetched word, reads the register file, and emits one
// registered decode bundle with a done pulse. Defining DECODE_RV32M_EN adds RV32M MULDIV decode.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] pc,
  input  logic [31:0] command,
  output logic        busy,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        done,
  output logic [31:0] pc_out,
  output logic [3:0]  opclass,
  output logic [4:0]  alu_op,
  output logic [2:0]  funct3,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic [31:0] imm,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic        illegal
);
  typedef enum logic [1:0] {IDLE, READ, OUT} state_t;

  localparam logic [3:0] C_ALU = 4'd0, C_ALUI = 4'd1, C_LOAD = 4'd2, C_STORE = 4'd3,
                         C_BRANCH = 4'd4, C_JAL = 4'd5, C_JALR = 4'd6, C_LUI = 4'd7,
                         C_AUIPC = 4'd8, C_SYSTEM = 4'd9, C_MULDIV = 4'd10, C_ILL = 4'd15;

  state_t      state;
  logic [31:0] cmd_q, pc_q;

  logic [3:0]  d_cls;
  logic [31:0] d_imm;
  logic        d_alt, d_md, d_rw;
  logic [6:0]  f7;

  assign f7 = cmd_q[31:25];

  always_comb begin
    d_cls = C_ILL;
    d_imm = 32'd0;
    d_alt = 1'b0;
    d_md  = 1'b0;
    case (cmd_q[6:0])
      7'b0110011: begin
        if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          d_cls = C_ALU;
          d_alt = cmd_q[30];
        end
`ifdef DECODE_RV32M_EN
        else if (f7 == 7'b0000001) begin
          d_cls = C_MULDIV;
          d_md  = 1'b1;
        end
`endif
      end
      7'b0010011: begin
        d_cls = C_ALUI;
        d_imm = {{20{cmd_q[31]}}, cmd_q[31:20]};
        d_alt = (cmd_q[14:12] == 3'b101) ? cmd_q[30] : 1'b0;
      end
      7'b0000011: begin
        d_cls = C_LOAD;
        d_imm = {{20{cmd_q[31]}}, cmd_q[31:20]};
      end
      7'b0100011: begin
        d_cls = C_STORE;
        d_imm = {{20{cmd_q[31]}}, cmd_q[31:25], cmd_q[11:7]};
      end
      7'b1100011: begin
        d_cls = C_BRANCH;
        d_imm = {{20{cmd_q[31]}}, cmd_q[7], cmd_q[30:25], cmd_q[11:8], 1'b0};
      end
      7'b1101111: begin
        d_cls = C_JAL;
        d_imm = {{12{cmd_q[31]}}, cmd_q[19:12], cmd_q[20], cmd_q[30:21], 1'b0};
      end
      7'b1100111: begin
        d_cls = C_JALR;
        d_imm = {{20{cmd_q[31]}}, cmd_q[31:20]};
      end
      7'b0110111: begin
        d_cls = C_LUI;
        d_imm = {cmd_q[31:12], 12'd0};
      end
      7'b0010111: begin
        d_cls = C_AUIPC;
        d_imm = {cmd_q[31:12], 12'd0};
      end
      7'b1110011: begin
        d_cls = C_SYSTEM;
        d_imm = {{20{cmd_q[31]}}, cmd_q[31:20]};
      end
      default: d_cls = C_ILL;
    endcase
  end

  // Store, branch, system and illegal never write back; x0 is never a real destination.
  always_comb begin
    d_rw = 1'b0;
    case (d_cls)
      C_ALU, C_ALUI, C_LOAD, C_JAL, C_JALR, C_LUI, C_AUIPC, C_MULDIV:
        d_rw = (cmd_q[11:7] != 5'd0);
      default: d_rw = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_q     <= 32'd0;
      pc_q      <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rs1_addr  <= 5'd0;
      rs2_addr  <= 5'd0;
      pc_out    <= 32'd0;
      opclass   <= 4'd0;
      alu_op    <= 5'd0;
      funct3    <= 3'd0;
      rd        <= 5'd0;
      reg_write <= 1'b0;
      imm       <= 32'd0;
      src1      <= 32'd0;
      src2      <= 32'd0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE, OUT: begin
          done <= 1'b0;
          busy <= enable;
          if (enable) begin
            cmd_q    <= command;
            pc_q     <= pc;
            rs1_addr <= command[19:15];
            rs2_addr <= command[24:20];
            state    <= READ;
          end
        end
        READ: begin
          busy      <= 1'b1;
          done      <= 1'b1;
          pc_out    <= pc_q;
          opclass   <= d_cls;
          alu_op    <= {d_md, d_alt, cmd_q[14:12]};
          funct3    <= cmd_q[14:12];
          rd        <= cmd_q[11:7];
          reg_write <= d_rw;
          imm       <= d_imm;
          src1      <= (rs1_addr == 5'd0) ? 32'd0 : rs1_data;
          src2      <= (rs2_addr == 5'd0) ? 32'd0 : rs2_data;
          illegal   <= (d_cls == C_ILL);
          state     <= OUT;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the core, directly downstream of instruction fetch. It takes the fetched word and its PC on the fetch `done` pulse and drives register-file read addresses. It returns one registered bundle with opclass, ALU op, destination, sign-extended immediate and both source operands, plus a one-cycle `done` pulse for execute. ISA is RV32I, with optional RV32M.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `enable` in 1: one-cycle pulse from fetch `done`; samples `pc`, `command`.
- `pc` in 32: PC of fetched word.
- `command` in 32: fetched instruction.
- `busy` out 1: high from the cycle after `enable` until `done` inclusive.
- `rs1_addr` out 5: register-file read address 1, registered.
- `rs2_addr` out 5: register-file read address 2, registered.
- `rs1_data` in 32: combinational read data for `rs1_addr`.
- `rs2_data` in 32: combinational read data for `rs2_addr`.
- `done` out 1: one-cycle pulse; the output bundle is valid and held until the next `done`.
- `pc_out` out 32: PC of decoded word.
- `opclass` out 4:
  - 0 ALU, 1 ALUI, 2 LOAD, 3 STORE, 4 BRANCH.
  - 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 10 MULDIV.
  - 15 ILLEGAL.
- `alu_op` out 5: {muldiv, alt, funct3}.
- `funct3` out 3: raw `command[14:12]`.
- `rd` out 5: destination register.
- `reg_write` out 1: write-back required.
- `imm` out 32: sign-extended immediate.
- `src1` out 32: rs1 operand.
- `src2` out 32: rs2 operand.
- `illegal` out 1: undecodable instruction.

## Operation
FSM states: IDLE, READ, OUT.
- IDLE:
  - On `enable`: latch `command` and `pc`.
  - Drive `rs1_addr`=`command[19:15]`, `rs2_addr`=`command[24:20]`.
  - Go to READ.
- READ:
  - Capture `src1`/`src2`; register number 0 forces a zero operand regardless of `rs*_data`.
  - Register all decoded fields; pulse `done`; go to OUT.
- OUT: behaves as IDLE; a new `enable` here starts the next decode. The bundle holds until overwritten.
- `enable` while in READ is ignored; fetch never issues one then.

Immediate by format:
- I: `cmd[31:20]` sign-extended.
- S: {`cmd[31:25]`,`cmd[11:7]`}.
- B: {`cmd[31]`,`cmd[7]`,`cmd[30:25]`,`cmd[11:8]`,0}.
- U: {`cmd[31:12]`,12'b0}.
- J: {`cmd[31]`,`cmd[19:12]`,`cmd[20]`,`cmd[30:21]`,0}.
- R-type: `imm`=0.

`alu_op`:
- `alt`=`cmd[30]` for R-type.
- `alt`=`cmd[30]` for ALUI with funct3=101 (SRAI).
- `alt`=0 for all other instructions.

`reg_write`:
- Set for ALU, ALUI, LOAD, JAL, JALR, LUI, AUIPC, MULDIV.
- Forced 0 when `rd`=0 or when the instruction is illegal.

`illegal`:
- Set when `cmd[1:0]`≠11, the opcode is unknown, or R-type funct7 is not 0000000/0100000.
- When set: `opclass`=15, `reg_write`=0; `done` still pulses.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, all other outputs 0.
- `enable` sampled in cycle N: `rs*_addr` valid and `busy`=1 in N+1; `done`=1 and bundle valid in N+2. Latency is 2 cycles.
- Throughput: one instruction per 2 cycles; `enable` at N+2 is accepted.
- `done` is high for exactly one cycle per accepted `enable`.
- Reset asserted in any state aborts the decode: no `done`, and outputs return to reset values the next cycle.
- `rs*_data` is sampled only at the READ→OUT edge.

## Configuration
`DECODE_RV32M_EN`:
- Defined: opcode 0110011 with funct7 0000001 decodes as MULDIV, with `alu_op`={1,0,funct3} and `reg_write` per the `rd` rule.
- Undefined: that encoding is illegal (`opclass`=15, `illegal`=1, `reg_write`=0).

## Test plan
- Reset, then `enable` with `command`=0x00500093 (addi x1,x0,5), `pc`=0x100:
  - `done` at N+2 only.
  - `opclass`=1, `imm`=5, `rd`=1, `reg_write`=1, `src1`=0 even with `rs1_data`=0xFFFFFFFF, `pc_out`=0x100.
- `command`=0x40208133 (sub x2,x1,x2), `rs1_data`=7, `rs2_data`=3:
  - `opclass`=0, `alu_op`=0b01000, `src1`=7, `src2`=3.
- `command`=0xFE000EE3 (beq x0,x0,-4):
  - `opclass`=4, `imm`=0xFFFFFFFC, `reg_write`=0.
- `command`=0x022081B3 (mul x3,x1,x2):
  - With `DECODE_RV32M_EN`: `opclass`=10, `alu_op`=0b10000.
  - Without it: `illegal`=1, `opclass`=15.
- `enable` pulses at N and N+2:
  - two `done` pulses at N+2 and N+4, each with its own `pc_out`.
  - `rst` asserted at N+1 on a fresh decode: no `done`, all outputs 0 at N+2.
